// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline register stage.
// Main register M drives out_data/out_valid directly from flops. Defining
// PIPE_STAGE_SKID_EN adds a skid register S so in_ready can be a registered
// (S empty) signal. Without the macro the stage holds one entry and in_ready
// looks through to out_ready combinationally.
module pipe_stage_reg #(
  parameter int DATA_W      = 32,
  parameter int ZERO_BUBBLE = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              in_ready_o,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_data_o,
  input  logic              out_ready_i,
  output logic [1:0]        occupancy_o
);

  logic              m_vld_q, m_vld_d;
  logic [DATA_W-1:0] m_dat_q, m_dat_d;
  logic [1:0]        occ_q, occ_d;
  logic              in_xfer, out_xfer;

  assign out_xfer    = m_vld_q & out_ready_i;
  assign in_xfer     = in_valid_i & in_ready_o;
  assign out_valid_o = m_vld_q;
  assign out_data_o  = m_dat_q;
  assign occupancy_o = occ_q;

`ifdef PIPE_STAGE_SKID_EN
  logic              s_vld_q, s_vld_d;
  logic [DATA_W-1:0] s_dat_q, s_dat_d;
  logic              rdy_q;

  // in_ready is a flop: low in reset, then tracks "S will be empty"
  assign in_ready_o = rdy_q;

  // Next state for M and S; flush dominates, S always drains into M first
  always_comb begin
    m_vld_d = m_vld_q;
    m_dat_d = m_dat_q;
    s_vld_d = s_vld_q;
    s_dat_d = s_dat_q;
    if (flush_i) begin
      m_vld_d = 1'b0;
      s_vld_d = 1'b0;
      if (ZERO_BUBBLE != 0) m_dat_d = '0;
    end else if (!m_vld_q || out_xfer) begin
      if (s_vld_q) begin
        m_vld_d = 1'b1;
        m_dat_d = s_dat_q;
        s_vld_d = in_xfer;
        if (in_xfer) s_dat_d = in_data_i;
      end else if (in_xfer) begin
        m_vld_d = 1'b1;
        m_dat_d = in_data_i;
      end else begin
        m_vld_d = 1'b0;
        if (ZERO_BUBBLE != 0) m_dat_d = '0;
      end
    end else if (in_xfer) begin
      s_vld_d = 1'b1;
      s_dat_d = in_data_i;
    end
    occ_d = {1'b0, m_vld_d} + {1'b0, s_vld_d};
  end

  // Skid register and registered ready
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s_vld_q <= 1'b0;
      s_dat_q <= '0;
      rdy_q   <= 1'b0;
    end else begin
      s_vld_q <= s_vld_d;
      s_dat_q <= s_dat_d;
      rdy_q   <= ~s_vld_d;
    end
  end
`else
  logic rdy_en_q;

  // Ready looks through to out_ready; held low until the first edge after reset
  assign in_ready_o = rdy_en_q & (~m_vld_q | out_ready_i);

  // Next state for M; flush dominates, otherwise reload on empty or drain
  always_comb begin
    m_vld_d = m_vld_q;
    m_dat_d = m_dat_q;
    if (flush_i) begin
      m_vld_d = 1'b0;
      if (ZERO_BUBBLE != 0) m_dat_d = '0;
    end else if (!m_vld_q || out_xfer) begin
      if (in_xfer) begin
        m_vld_d = 1'b1;
        m_dat_d = in_data_i;
      end else begin
        m_vld_d = 1'b0;
        if (ZERO_BUBBLE != 0) m_dat_d = '0;
      end
    end
    occ_d = {1'b0, m_vld_d};
  end

  // Ready-enable flop released on the first edge out of reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rdy_en_q <= 1'b0;
    else         rdy_en_q <= 1'b1;
  end
`endif

  // Main register and registered occupancy
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_vld_q <= 1'b0;
      m_dat_q <= '0;
      occ_q   <= 2'd0;
    end else begin
      m_vld_q <= m_vld_d;
      m_dat_q <= m_dat_d;
      occ_q   <= occ_d;
    end
  end

endmodule
